// File: rtl/dsp_slice_param.sv
// dsp_slice_param: pipelined dual signed multiplier with sum/chain/pre-add, accumulate and saturation
// Ports: clk_i/clr_i clock and async reset, enable_i global clock enable, in_valid_i beat qualifier,
//   ax_i/ay_i/bx_i/by_i operands, mode_i/sub_i/negate_i/accumulate_i/loadconst_i/saturate_i beat controls,
//   constant_i preload, chainin_i cascade in; out_valid_o, resulta_o/resultb_o products,
//   result_o/chainout_o combined result, overflow_o overflow flag for the result on result_o.
module dsp_slice_param #(
  parameter int DWIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int PIPE_STAGES = 3
) (
  input  logic                   clk_i,
  input  logic                   clr_i,
  input  logic                   enable_i,
  input  logic                   in_valid_i,
  input  logic [DWIDTH-1:0]      ax_i,
  input  logic [DWIDTH-1:0]      ay_i,
  input  logic [DWIDTH-1:0]      bx_i,
  input  logic [DWIDTH-1:0]      by_i,
  input  logic [1:0]             mode_i,
  input  logic                   sub_i,
  input  logic                   negate_i,
  input  logic                   accumulate_i,
  input  logic                   loadconst_i,
  input  logic [ACC_WIDTH-1:0]   constant_i,
  input  logic                   saturate_i,
  input  logic [ACC_WIDTH-1:0]   chainin_i,
  output logic                   out_valid_o,
  output logic [2*DWIDTH-1:0]    resulta_o,
  output logic [2*DWIDTH-1:0]    resultb_o,
  output logic [ACC_WIDTH-1:0]   result_o,
  output logic [ACC_WIDTH-1:0]   chainout_o,
  output logic                   overflow_o
);
  localparam int PW = 2*DWIDTH;
  localparam int D = PIPE_STAGES > 1 ? PIPE_STAGES-1 : 1;
  localparam int AM = ACC_WIDTH-1;
  typedef struct packed {
    logic v;
    logic [1:0] mode;
    logic sub, neg, acc, ld, sat;
    logic [ACC_WIDTH-1:0] k, chain;
  } ctl_t;
  typedef struct packed {
    ctl_t c;
    logic [PW-1:0] pa, pb;
  } beat_t;
  ctl_t in_q;
  logic [DWIDTH-1:0] ax_q, ay_q, bx_q, by_q;
  beat_t pipe_q [D];
  beat_t cur, t;
  logic [DWIDTH:0] pre;
  logic [PW-1:0] pm, pn, pbn;
  logic [ACC_WIDTH-1:0] sa, sb, s0, s, base, sum_d, res_d, acc_q, result_q;
  logic [PW-1:0] resa_q, resb_q;
  logic ovf_d, ovf_q, vld_q;
  always_ff @(posedge clk_i or posedge clr_i)
    if (clr_i) begin
      in_q <= '0;
      {ax_q, ay_q, bx_q, by_q} <= '0;
    end else if (enable_i) begin
      in_q <= {in_valid_i, mode_i, sub_i, negate_i, accumulate_i, loadconst_i, saturate_i, constant_i, chainin_i};
      {ax_q, ay_q, bx_q, by_q} <= {ax_i, ay_i, bx_i, by_i};
    end
  // pre-add is one bit wider than the operands so ax+bx never wraps before the multiply
  assign pre = {ax_q[DWIDTH-1], ax_q} + {bx_q[DWIDTH-1], bx_q};
  assign pm = $signed({{(DWIDTH-1){pre[DWIDTH]}}, pre}) * $signed({{DWIDTH{ay_q[DWIDTH-1]}}, ay_q});
  assign pn = $signed({{DWIDTH{ax_q[DWIDTH-1]}}, ax_q}) * $signed({{DWIDTH{ay_q[DWIDTH-1]}}, ay_q});
  assign pbn = $signed({{DWIDTH{bx_q[DWIDTH-1]}}, bx_q}) * $signed({{DWIDTH{by_q[DWIDTH-1]}}, by_q});
  assign cur = {in_q, in_q.mode == 2'b11 ? pm : pn, pbn};
  always_ff @(posedge clk_i or posedge clr_i)
    if (clr_i) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
    end else if (enable_i) begin
      pipe_q[0] <= cur;
      for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  generate
    if (PIPE_STAGES == 1) begin : g_short
      assign t = cur;
    end else begin : g_pipe
      assign t = pipe_q[D-1];
    end
  endgenerate
  always_comb begin
    sa = {{(ACC_WIDTH-PW){t.pa[PW-1]}}, t.pa};
    sb = {{(ACC_WIDTH-PW){t.pb[PW-1]}}, t.pb};
    s0 = t.c.mode == 2'b11 ? sa : t.c.sub ? sa - sb : sa + sb;
    s = t.c.neg ? -s0 : s0;
    base = t.c.mode == 2'b10 ? t.c.chain : t.c.acc ? acc_q : t.c.ld ? t.c.k : '0;
    sum_d = base + s;
    ovf_d = (base[AM] == s[AM]) && (sum_d[AM] != base[AM]);
    // clamp toward the sign both operands share
    res_d = ovf_d && t.c.sat ? {base[AM], {AM{~base[AM]}}} : sum_d;
  end
  // final stage closes the single-cycle accumulator loop; bubbles leave every result register alone
  always_ff @(posedge clk_i or posedge clr_i)
    if (clr_i) begin
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      {acc_q, result_q, resa_q, resb_q} <= '0;
    end else if (enable_i) begin
      vld_q <= t.c.v;
      if (t.c.v && t.c.mode == 2'b00) begin
        resa_q <= t.pa;
        resb_q <= t.pb;
        result_q <= sa;
        ovf_q <= 1'b0;
      end else if (t.c.v) begin
        result_q <= res_d;
        acc_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  assign out_valid_o = vld_q;
  assign resulta_o = resa_q;
  assign resultb_o = resb_q;
  assign result_o = result_q;
  assign chainout_o = result_q;
  assign overflow_o = ovf_q;
endmodule
